div_operand_fifo: RTL and testbench

DIV_OPERAND_FIFO -- requirements
Module: div_operand_fifo

---
 rtl/div_operand_fifo.sv | 125 ++++++++++++
 tb/tb_div_operand_fifo.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_operand_fifo.sv
// Show-ahead operand queue for the divide/modulo stage; head valid 1 cycle after enqueue, no bypass.
// in_ready depends only on registered occupancy; a pop while full frees the slot for the next cycle.
module div_operand_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_numerator,
    input  logic [7:0]               in_denominator,
    input  logic [15:0]              in_dividend_mod,
    input  logic [7:0]               in_divisor_mod,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              numerator,
    output logic [7:0]               denominator,
    output logic [15:0]              dividend_mod,
    output logic [7:0]               divisor_mod,
    output logic                     div_by_zero,
    output logic                     mod_by_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               zero_err_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [15:0] numerator;
        logic [7:0]  denominator;
        logic [15:0] dividend_mod;
        logic [7:0]  divisor_mod;
        logic        div_by_zero;
        logic        mod_by_zero;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          in_entry;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            in_any_zero;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        in_entry              = '0;
        in_entry.numerator    = in_numerator;
        in_entry.denominator  = in_denominator;
        in_entry.dividend_mod = in_dividend_mod;
        in_entry.divisor_mod  = in_divisor_mod;
        in_entry.div_by_zero  = (in_denominator == 8'd0);
        in_entry.mod_by_zero  = (in_divisor_mod == 8'd0);
    end

    assign in_any_zero = in_entry.div_by_zero || in_entry.mod_by_zero;

    // Storage is never reset; pointers and count gate its visibility.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_err_cnt <= '0;
        end else if (push && in_any_zero && (zero_err_cnt != 8'hFF)) begin
            zero_err_cnt <= zero_err_cnt + 8'd1;
        end
    end

    // Head outputs are forced to zero while empty so stale storage never leaks.
    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign numerator    = head.numerator;
    assign denominator  = head.denominator;
    assign dividend_mod = head.dividend_mod;
    assign divisor_mod  = head.divisor_mod;
    assign div_by_zero  = head.div_by_zero;
    assign mod_by_zero  = head.mod_by_zero;

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && count == FULL_CNT));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));

endmodule

// File: tb/tb_div_operand_fifo.sv
module tb_div_operand_fifo;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_numerator;
    logic [7:0]    in_denominator;
    logic [15:0]   in_dividend_mod;
    logic [7:0]    in_divisor_mod;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   numerator;
    logic [7:0]    denominator;
    logic [15:0]   dividend_mod;
    logic [7:0]    divisor_mod;
    logic          div_by_zero;
    logic          mod_by_zero;
    logic [CW-1:0] count;
    logic [7:0]    zero_err_cnt;

    typedef struct {
        logic [15:0] num;
        logic [7:0]  den;
        logic [15:0] dm;
        logic [7:0]  mdv;
    } req_t;

    req_t mq[$];
    int   model_err;
    int   n_checks;
    int   n_fail;

    div_operand_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_numerator(in_numerator), .in_denominator(in_denominator),
        .in_dividend_mod(in_dividend_mod), .in_divisor_mod(in_divisor_mod),
        .out_valid(out_valid), .out_ready(out_ready),
        .numerator(numerator), .denominator(denominator),
        .dividend_mod(dividend_mod), .divisor_mod(divisor_mod),
        .div_by_zero(div_by_zero), .mod_by_zero(mod_by_zero),
        .count(count), .zero_err_cnt(zero_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit v, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] c, input logic [7:0] d);
        in_valid        = v;
        in_numerator    = a;
        in_denominator  = b;
        in_dividend_mod = c;
        in_divisor_mod  = d;
    endtask

    // Advances one clock and applies the queue rules to the reference model.
    task automatic tick();
        bit   p, q;
        req_t r;
        p = in_valid && (mq.size() < DEPTH);
        q = out_ready && (mq.size() > 0);
        r.num = in_numerator; r.den = in_denominator;
        r.dm  = in_dividend_mod; r.mdv = in_divisor_mod;
        @(posedge clk);
        if (q) void'(mq.pop_front());
        if (p) begin
            mq.push_back(r);
            if ((r.den == 0 || r.mdv == 0) && model_err < 255) model_err++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        mq.delete();
        model_err = 0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_checks += 4;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        if ({numerator, denominator, zero_err_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got %h want 0", {numerator, denominator, zero_err_cnt});
        end
        rst = 1'b0;
        mq.delete();
        model_err = 0;
        out_ready = 1'b0;
        drive(1, 16'd42, 8'd3, 16'd9, 8'd2);
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks += 2;
        if (count !== CW'(1)) begin n_fail++; $display("FAIL first_push_count got %0d want 1", count); end
        if (numerator !== 16'd42) begin n_fail++; $display("FAIL first_push_num got %0d want 42", numerator); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_single_push();
        drive(1, 16'd100, 8'd7, 16'd50, 8'd6);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass got %b want 0", out_valid); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks += 4;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
        if ({numerator, denominator, dividend_mod, divisor_mod} !== {16'd100, 8'd7, 16'd50, 8'd6}) begin
            n_fail++; $display("FAIL single_ops got %h want %h", {numerator, denominator, dividend_mod, divisor_mod},
                               {16'd100, 8'd7, 16'd50, 8'd6});
        end
        if ({div_by_zero, mod_by_zero} !== 2'b00) begin n_fail++; $display("FAIL single_flags got %b want 00", {div_by_zero, mod_by_zero}); end
        if (count !== CW'(1)) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 16'(100 + i), 8'(i + 1), 16'(200 + i), 8'(10 + i));
            tick();
        end
        n_checks += 2;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count got %0d want %0d", count, DEPTH); end
        drive(1, 16'hdead, 8'h55, 16'hbeef, 8'h66);
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks += 2;
        if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_ignore_count got %0d want %0d", count, DEPTH); end
        if (numerator !== 16'd100) begin n_fail++; $display("FAIL full_ignore_head got %0d want 100", numerator); end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if ({numerator, denominator, dividend_mod, divisor_mod} !== {16'(100 + i), 8'(i + 1), 16'(200 + i), 8'(10 + i)}) begin
                n_fail++; $display("FAIL drain_order[%0d] got %0d want %0d", i, numerator, 100 + i);
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks += 2;
        if (count !== '0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got count=%0d valid=%b want 0/0", count, out_valid); end
        if ({numerator, denominator, dividend_mod, divisor_mod, div_by_zero, mod_by_zero} !== '0) begin
            n_fail++; $display("FAIL drain_zero_out got %h want 0", {numerator, denominator, dividend_mod, divisor_mod});
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 16'(300 + i), 8'd3, 16'd1, 8'd4);
            tick();
        end
        drive(1, 16'd777, 8'd9, 16'd8, 8'd7);
        out_ready = 1'b1;
        tick();
        n_checks += 3;
        if (count !== CW'(DEPTH - 1)) begin n_fail++; $display("FAIL fullpp_count got %0d want %0d", count, DEPTH - 1); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpp_ready got %b want 1", in_ready); end
        if (numerator !== 16'd301) begin n_fail++; $display("FAIL fullpp_head got %0d want 301", numerator); end
        out_ready = 1'b0;
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++;
        if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fullpp_refill got %0d want %0d", count, DEPTH); end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (numerator !== mq[0].num) begin n_fail++; $display("FAIL fullpp_drain[%0d] got %0d want %0d", i, numerator, mq[0].num); end
            if (i == DEPTH - 1) begin
                n_checks++;
                if (numerator !== 16'd777) begin n_fail++; $display("FAIL fullpp_last got %0d want 777", numerator); end
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_zero_flags();
        do_reset();
        drive(1, 16'd10, 8'd0, 16'd20, 8'd0);
        tick();
        drive(1, 16'd11, 8'd5, 16'd21, 8'd0);
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks += 2;
        if ({div_by_zero, mod_by_zero} !== 2'b11) begin n_fail++; $display("FAIL zflags_first got %b want 11", {div_by_zero, mod_by_zero}); end
        if (zero_err_cnt !== 8'd2) begin n_fail++; $display("FAIL zerr_two got %0d want 2", zero_err_cnt); end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({div_by_zero, mod_by_zero} !== 2'b01) begin n_fail++; $display("FAIL zflags_second got %b want 01", {div_by_zero, mod_by_zero}); end
        tick();
        for (int i = 0; i < 300; i++) begin
            drive(1, 16'(i), 8'd0, 16'(i), 8'($urandom_range(0, 3)));
            tick();
        end
        drive(0, 0, 0, 0, 0);
        tick();
        out_ready = 1'b0;
        n_checks += 2;
        if (zero_err_cnt !== 8'hFF) begin n_fail++; $display("FAIL zerr_sat got %0h want ff", zero_err_cnt); end
        if (count !== '0) begin n_fail++; $display("FAIL zerr_drain_count got %0d want 0", count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'(500 + i), 8'(i), 16'd1, 8'd1);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        n_checks += 2;
        if (count !== CW'(3)) begin n_fail++; $display("FAIL arst_pre_count got %0d want 3", count); end
        if (zero_err_cnt !== 8'(model_err)) begin n_fail++; $display("FAIL arst_pre_zerr got %0d want %0d", zero_err_cnt, model_err); end
        #2 rst = 1'b1;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0 || count !== '0) begin n_fail++; $display("FAIL arst_clear got valid=%b count=%0d want 0/0", out_valid, count); end
        if (zero_err_cnt !== 8'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_zerr got %0d ready=%b want 0/1", zero_err_cnt, in_ready); end
        if ({numerator, denominator, div_by_zero} !== '0) begin n_fail++; $display("FAIL arst_head got %h want 0", {numerator, denominator, div_by_zero}); end
        #1 rst = 1'b0;
        mq.delete();
        model_err = 0;
        drive(1, 16'd900, 8'd12, 16'd33, 8'd4);
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks += 2;
        if (out_valid !== 1'b1 || count !== CW'(1)) begin n_fail++; $display("FAIL arst_repush got valid=%b count=%0d want 1/1", out_valid, count); end
        if (numerator !== 16'd900 || denominator !== 8'd12) begin n_fail++; $display("FAIL arst_repush_ops got %0d/%0d want 900/12", numerator, denominator); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] e_num, e_dm;
        logic [7:0]  e_den, e_mdv;
        logic        e_v;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            drive($urandom_range(0, 9) < 6, 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                  16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
            out_ready = ($urandom_range(0, 9) < ((c / 1000) % 2 == 0 ? 5 : 8));
            tick();
            e_v = (mq.size() > 0);
            {e_num, e_den, e_dm, e_mdv} = '0;
            if (e_v) {e_num, e_den, e_dm, e_mdv} = {mq[0].num, mq[0].den, mq[0].dm, mq[0].mdv};
            n_checks += 5;
            if (count !== CW'(mq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, count, mq.size()); end
            if ({out_valid, in_ready} !== {e_v, mq.size() < DEPTH}) begin
                n_fail++; $display("FAIL rnd_hs c=%0d got %b want %b", c, {out_valid, in_ready}, {e_v, mq.size() < DEPTH});
            end
            if ({numerator, denominator, dividend_mod, divisor_mod} !== {e_num, e_den, e_dm, e_mdv}) begin
                n_fail++; $display("FAIL rnd_head c=%0d got %h want %h", c, {numerator, denominator, dividend_mod, divisor_mod}, {e_num, e_den, e_dm, e_mdv});
            end
            if ({div_by_zero, mod_by_zero} !== {e_v && e_den == 0, e_v && e_mdv == 0}) begin
                n_fail++; $display("FAIL rnd_flags c=%0d got %b want %b", c, {div_by_zero, mod_by_zero}, {e_v && e_den == 0, e_v && e_mdv == 0});
            end
            if (zero_err_cnt !== 8'(model_err)) begin n_fail++; $display("FAIL rnd_zerr c=%0d got %0d want %0d", c, zero_err_cnt, model_err); end
        end
        drive(0, 0, 0, 0, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_err = 0;
        out_ready = 1'b0;
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_single_push();
        test_fill_drain();
        test_full_push_pop();
        test_zero_flags();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
